shift_sequencer: RTL

- Multi-cycle, iterative generator for the ARM data-processing second operand (Val2) and the shifter carry-out.
- Replaces the single-cycle barrel shift with a STEP-bit-per-cycle shift engine.
- Sits between ID/EX operand registers and the ALU. The pipeline controller stalls EX while busy=1.
- Handles the immediate-rotate, shift-by-immediate (LSL/LSR/ASR/ROR/RRX) and load/store-offset (los) forms.

---
 rtl/shift_sequencer_pkg.sv | 78 +++++++
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_sequencer_step.sv | 58 +++++
 rtl/shift_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the iterative Val2 / shifter-carry generator:
// shift kinds, FSM states, latched-operand record and the operand decoder.
package shift_sequencer_pkg;

  localparam int unsigned DataW = 32;

  // Architectural shift-type field encoding (instruction bits [6:5]).
  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  // Internal shift kind; RRX gets its own code since it is not a plain rotate.
  typedef enum logic [2:0] {
    KindLsl = 3'b000,
    KindLsr = 3'b001,
    KindAsr = 3'b010,
    KindRor = 3'b011,
    KindRrx = 3'b100
  } kind_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StShift = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Decoded operand: starting data, shift kind and total shift amount (0..32).
  typedef struct packed {
    logic [DataW-1:0] data;
    kind_e            kind;
    logic [5:0]       amount;
  } op_t;

  // Decode the three operand forms; los beats imm, imm beats register shift.
  function automatic op_t decode_op(input logic [11:0]      shift_operand,
                                    input logic [DataW-1:0] val_rm,
                                    input logic             imm,
                                    input logic             los);
    op_t op;
    op.data   = '0;
    op.kind   = KindLsl;
    op.amount = '0;
    if (los) begin
      op.data = {20'b0, shift_operand};
    end else if (imm) begin
      op.data   = {24'b0, shift_operand[7:0]};
      op.kind   = KindRor;
      op.amount = {1'b0, shift_operand[11:8], 1'b0};
    end else begin
      op.data   = val_rm;
      op.amount = {1'b0, shift_operand[11:7]};
      case (shift_operand[6:5])
        ShLsl: op.kind = KindLsl;
        ShLsr: begin
          op.kind = KindLsr;
          if (shift_operand[11:7] == 5'd0) op.amount = 6'd32;
        end
        ShAsr: begin
          op.kind = KindAsr;
          if (shift_operand[11:7] == 5'd0) op.amount = 6'd32;
        end
        default: begin
          // ROR #0 encodes RRX: a single one-bit rotate through carry.
          if (shift_operand[11:7] == 5'd0) begin
            op.kind   = KindRrx;
            op.amount = 6'd1;
          end else begin
            op.kind = KindRor;
          end
        end
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the EX-stage operand registers and the
// shift sequencer.
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic             start;
  logic [DataW-1:0] val_rm;
  logic [11:0]      shift_operand;
  logic             imm;
  logic             los;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [DataW-1:0] val2;
  logic             shifter_carry;

  modport master (
    output start, val_rm, shift_operand, imm, los, carry_in,
    input  busy, done, val2, shifter_carry
  );

  modport slave (
    input  start, val_rm, shift_operand, imm, los, carry_in,
    output busy, done, val2, shifter_carry
  );

endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-chunk shifter: moves data by k bits (0..8) in the
// requested direction and reports the last bit shifted out as carry.
module shift_sequencer_step
  import shift_sequencer_pkg::*;
(
  input  logic [DataW-1:0] data_i,
  input  kind_e            kind_i,
  input  logic [3:0]       k_i,
  input  logic             carry_i,
  output logic [DataW-1:0] data_o,
  output logic             carry_o
);

  // One guard bit beside the data catches the last bit shifted out.
  logic [DataW:0]   lsl_w;
  logic [DataW:0]   lsr_w;
  logic [DataW:0]   asr_w;
  logic [DataW-1:0] ror_w;

  // Compute every candidate result, then select by kind.
  always_comb begin
    lsl_w = {1'b0, data_i} << k_i;
    lsr_w = {data_i, 1'b0} >> k_i;
    asr_w = $signed({data_i, 1'b0}) >>> k_i;
    ror_w = (data_i >> k_i) | (data_i << (6'd32 - {2'b00, k_i}));

    data_o  = data_i;
    carry_o = carry_i;
    if (kind_i == KindRrx) begin
      data_o  = {carry_i, data_i[DataW-1:1]};
      carry_o = data_i[0];
    end else if (k_i != 4'd0) begin
      case (kind_i)
        KindLsl: begin
          data_o  = lsl_w[DataW-1:0];
          carry_o = lsl_w[DataW];
        end
        KindLsr: begin
          data_o  = lsr_w[DataW:1];
          carry_o = lsr_w[0];
        end
        KindAsr: begin
          data_o  = asr_w[DataW:1];
          carry_o = asr_w[0];
        end
        KindRor: begin
          data_o  = ror_w;
          carry_o = ror_w[DataW-1];
        end
        default: begin
          data_o  = data_i;
          carry_o = carry_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative ARM Val2 generator: decodes the second operand in LOAD, then
// shifts STEP bits per cycle until the full amount has been applied.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  shift_sequencer_if.slave bus_io
);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
    $error("shift_sequencer: STEP must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] StepRem = 6'(STEP);
  localparam logic [3:0] StepK   = 4'(STEP);

  state_e           state_q, state_d;
  logic [DataW-1:0] data_q, data_d;
  kind_e            kind_q, kind_d;
  logic [5:0]       rem_q, rem_d;
  logic             cin_q, cin_d;
  logic [DataW-1:0] val2_q, val2_d;
  logic             shc_q, shc_d;

  op_t              op;
  logic [3:0]       k;
  logic [DataW-1:0] step_data;
  logic             step_carry;

  // Decode the live inputs; only consumed while in LOAD.
  always_comb begin
    op = decode_op(bus_io.shift_operand, bus_io.val_rm, bus_io.imm, bus_io.los);
  end

  // Chunk size for this cycle: min(STEP, remaining).
  always_comb begin
    k = (rem_q < StepRem) ? rem_q[3:0] : StepK;
  end

  shift_sequencer_step u_step (
    .data_i  (data_q),
    .kind_i  (kind_q),
    .k_i     (k),
    .carry_i (cin_q),
    .data_o  (step_data),
    .carry_o (step_carry)
  );

  // Next-state and datapath updates for the four-state sequencer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    kind_d  = kind_q;
    rem_d   = rem_q;
    cin_d   = cin_q;
    val2_d  = val2_q;
    shc_d   = shc_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) state_d = StLoad;
      end
      StLoad: begin
        data_d = op.data;
        kind_d = op.kind;
        rem_d  = op.amount;
        cin_d  = bus_io.carry_in;
        if (op.amount == 6'd0) begin
          // Nothing to shift: result is the decoded data, carry passes through.
          val2_d  = op.data;
          shc_d   = bus_io.carry_in;
          state_d = StDone;
        end else begin
          state_d = StShift;
        end
      end
      StShift: begin
        data_d = step_data;
        rem_d  = rem_q - {2'b00, k};
        if (rem_q <= StepRem) begin
          val2_d  = step_data;
          shc_d   = step_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      kind_q  <= KindLsl;
      rem_q   <= '0;
      cin_q   <= 1'b0;
      val2_q  <= '0;
      shc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
      rem_q   <= rem_d;
      cin_q   <= cin_d;
      val2_q  <= val2_d;
      shc_q   <= shc_d;
    end
  end

  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.done          = (state_q == StDone);
  assign bus_io.val2          = val2_q;
  assign bus_io.shifter_carry = shc_q;

endmodule
